output_port_arbiter: RTL and testbench



---
 rtl/output_port_arbiter.sv | 103 ++++++++++
 tb/tb_output_port_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/output_port_arbiter.sv
// Two-requester round-robin arbiter that sequences loads into an 8-bit display latch.
// Every load is followed by a guaranteed hold window before the next grant.
module output_port_arbiter #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic             lo_n,
    output logic [WIDTH-1:0] out_bus,
    output logic             busy,
    output logic             grant_id
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_cnt;
    logic             r_last;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_lo_n;
    logic [WIDTH-1:0] r_out_bus;
    logic             r_busy;
    logic             r_grant_id;
    logic             w_grant;
    logic             w_win;

    // Arbitration and next-state decode; a tie goes to the requester not granted last.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_win       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_grant = req0 | req1;
                w_win   = (req0 && req1) ? ~r_last : req1;
                if (w_grant) w_state_nxt = S_LOAD;
            end
            S_LOAD: w_state_nxt = S_HOLD;
            S_HOLD: if (r_cnt == 8'd0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_last     <= 1'b1;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_lo_n     <= 1'b1;
            r_out_bus  <= '0;
            r_busy     <= 1'b0;
            r_grant_id <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_out_bus  <= w_win ? data1 : data0;
                        r_grant_id <= w_win;
                        r_last     <= w_win;
                        r_lo_n     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_ack0     <= ~w_win;
                        r_ack1     <= w_win;
                    end
                end
                S_LOAD: begin
                    r_lo_n <= 1'b1;
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    r_cnt  <= HOLD_LOAD;
                end
                S_HOLD: begin
                    // busy drops on the same edge that returns to IDLE
                    if (r_cnt == 8'd0) r_busy <= 1'b0;
                    else               r_cnt  <= r_cnt - 8'd1;
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign lo_n     = r_lo_n;
    assign out_bus  = r_out_bus;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: countdown-based transaction model checked every cycle,
// plus directed scenarios with literal expectations on grant order, data and spacing.
module tb_output_port_arbiter;

    localparam int W    = 8;
    localparam int HOLD = 4;

    logic         clk = 1'b0;
    logic         clr;
    logic         req0, req1;
    logic [W-1:0] data0, data1;
    logic         ack0, ack1, lo_n, busy, grant_id;
    logic [W-1:0] out_bus;

    output_port_arbiter #(.WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .clr(clr),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .ack0(ack0), .ack1(ack1), .lo_n(lo_n), .out_bus(out_bus),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: m_t counts remaining busy cycles; HOLD+1 marks the load cycle.
    int       m_t     = 0;
    bit       m_valid = 0;
    bit       m_last  = 1;
    bit       m_gid   = 0;
    bit       m_win;
    bit [W-1:0] m_out = '0;

    always @(posedge clk) begin
        cyc++;
        if (clr) begin
            m_t = 0; m_out = '0; m_gid = 0; m_last = 1; m_valid = 1;
        end else if (m_t == 0) begin
            if (req0 || req1) begin
                m_win  = (req0 && req1) ? !m_last : req1;
                m_out  = m_win ? data1 : data0;
                m_gid  = m_win;
                m_last = m_win;
                m_t    = HOLD + 1;
            end
        end else begin
            m_t--;
        end
    end

    int   lo_times[$];
    int   lo_gids[$];
    int   lo_data[$];
    int   busy_cnt = 0;
    int   overlap  = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy",     32'(busy),     32'(m_t > 0));
            chk("lo_n",     32'(lo_n),     32'(m_t != HOLD + 1));
            chk("ack0",     32'(ack0),     32'(m_t == HOLD + 1 && m_gid == 0));
            chk("ack1",     32'(ack1),     32'(m_t == HOLD + 1 && m_gid == 1));
            chk("out_bus",  32'(out_bus),  32'(m_out));
            chk("grant_id", 32'(grant_id), 32'(m_gid));
        end
        if (lo_n === 1'b0) begin
            lo_times.push_back(cyc);
            lo_gids.push_back(int'(grant_id));
            lo_data.push_back(int'(out_bus));
        end
        if (busy === 1'b1) busy_cnt++;
        if (ack0 === 1'b1 && ack1 === 1'b1) overlap++;
    end

    bit hold0 = 0, hold1 = 0;

    // Advance n cycles; a requester drops req on the edge that samples its ack, unless held.
    task automatic step(input int n);
        logic a0, a1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a0 = ack0; a1 = ack1;
            @(posedge clk);
            #1;
            if (a0 === 1'b1 && !hold0) req0 = 1'b0;
            if (a1 === 1'b1 && !hold1) req1 = 1'b0;
        end
    endtask

    task automatic clear_log();
        lo_times.delete(); lo_gids.delete(); lo_data.delete();
        busy_cnt = 0; overlap = 0;
    endtask

    function automatic int q_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    initial begin
        clr = 1'b1; req0 = 1'b1; req1 = 1'b0; data0 = 8'h0A; data1 = 8'h00;
        clear_log();

        // reset with a pending request: nothing may be granted
        step(1);
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_lo_n",  32'(lo_n),    32'd1);
        chk("rst_out",   32'(out_bus), 32'd0);
        step(1);
        chk("rst_ack0",  32'(ack0),    32'd0);
        chk("rst_nolo",  32'(lo_times.size()), 32'd0);

        // single request of 0x0A
        clr = 1'b0;
        clear_log();
        step(12);
        chk("t2_loads",  32'(lo_times.size()), 32'd1);
        chk("t2_data",   32'(q_at(lo_data, 0)), 32'h0A);
        chk("t2_gid",    32'(q_at(lo_gids, 0)), 32'd0);
        chk("t2_busy",   32'(busy_cnt), 32'(HOLD + 1));
        chk("t2_req0",   32'(req0), 32'd0);

        // simultaneous requests right after reset
        clr = 1'b1;
        step(1);
        clr = 1'b0; req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
        clear_log();
        step(16);
        chk("t3_loads",  32'(lo_times.size()), 32'd2);
        chk("t3_gid0",   32'(q_at(lo_gids, 0)), 32'd0);
        chk("t3_data0",  32'(q_at(lo_data, 0)), 32'h11);
        chk("t3_gid1",   32'(q_at(lo_gids, 1)), 32'd1);
        chk("t3_data1",  32'(q_at(lo_data, 1)), 32'h22);
        chk("t3_space",  32'(q_at(lo_times, 1) - q_at(lo_times, 0)), 32'(HOLD + 2));

        // fairness under continuous requests
        hold0 = 1; hold1 = 1; req0 = 1'b1; req1 = 1'b1;
        clear_log();
        step(26);
        for (int i = 0; i < 4; i++)
            chk("t4_alt", 32'(q_at(lo_gids, i)), 32'(i % 2));
        chk("t4_space",   32'(q_at(lo_times, 3) - q_at(lo_times, 2)), 32'(HOLD + 2));
        chk("t4_overlap", 32'(overlap), 32'd0);
        hold0 = 0; hold1 = 0;
        step(20);

        // data change one cycle after the grant edge
        req0 = 1'b1; data0 = 8'h55;
        clear_log();
        step(1);
        data0 = 8'hAA;
        step(3);
        chk("t5_hold_out", 32'(out_bus), 32'h55);
        step(6);
        chk("t5_loads",  32'(lo_times.size()), 32'd1);
        chk("t5_data",   32'(q_at(lo_data, 0)), 32'h55);

        // clr during the load cycle of a requester-1 transaction
        req1 = 1'b1; data1 = 8'h33;
        step(1);
        chk("t6_in_load", 32'(lo_n), 32'd0);
        clr = 1'b1;
        step(1);
        chk("t6_lo_n",  32'(lo_n),     32'd1);
        chk("t6_ack1",  32'(ack1),     32'd0);
        chk("t6_out",   32'(out_bus),  32'd0);
        chk("t6_busy",  32'(busy),     32'd0);
        clr = 1'b0; req0 = 1'b1; req1 = 1'b1; data0 = 8'h44; data1 = 8'h66;
        clear_log();
        step(3);
        chk("t6_gid",   32'(q_at(lo_gids, 0)), 32'd0);
        chk("t6_data",  32'(q_at(lo_data, 0)), 32'h44);
        step(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
